// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD/LCM engine: FSM state encoding and mode selectors.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_LCM = 1'b1;

endpackage

// File: rtl/gcd_lcm_engine_if.sv
// Request/result bundle between a controller (master) and the GCD/LCM engine (slave).
interface gcd_lcm_engine_if #(
    parameter int WIDTH = 8
);

    logic                 i_start;
    logic                 i_mode;
    logic [WIDTH-1:0]     i_a;
    logic [WIDTH-1:0]     i_b;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic [2*WIDTH-1:0]   o_y;

    modport master (
        output i_start, i_mode, i_a, i_b,
        input  o_busy, o_done, o_error, o_y
    );

    modport slave (
        input  i_start, i_mode, i_a, i_b,
        output o_busy, o_done, o_error, o_y
    );

endinterface

// File: rtl/gcd_lcm_dp.sv
// One combinational iteration step shared by GCD (subtract smaller from larger)
// and LCM (advance the smaller running multiple by its own operand).
module gcd_lcm_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] i_x,
    input  logic [2*WIDTH-1:0] i_z,
    input  logic [WIDTH-1:0]   i_opA,
    input  logic [WIDTH-1:0]   i_opB,
    input  logic               i_mode,
    output logic [2*WIDTH-1:0] o_xNext,
    output logic [2*WIDTH-1:0] o_zNext,
    output logic               o_equal
);

    logic               w_gcd;
    logic               w_selX;
    logic [2*WIDTH-1:0] w_lhs;
    logic [2*WIDTH-1:0] w_rhs;
    logic [2*WIDTH-1:0] w_res;

    // w_selX picks which register is rewritten this step; a single add/sub unit serves both modes.
    always_comb begin
        w_gcd  = (i_mode == MODE_GCD);
        w_selX = w_gcd ? (i_x > i_z) : (i_x < i_z);
        w_lhs  = w_selX ? i_x : i_z;
        if (w_gcd) begin
            w_rhs = w_selX ? i_z : i_x;
        end else begin
            w_rhs = w_selX ? {{WIDTH{1'b0}}, i_opA} : {{WIDTH{1'b0}}, i_opB};
        end
        w_res   = w_gcd ? (w_lhs - w_rhs) : (w_lhs + w_rhs);
        o_xNext = w_selX ? w_res : i_x;
        o_zNext = w_selX ? i_z   : w_res;
        o_equal = (i_x == i_z);
    end

endmodule

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle GCD/LCM engine: START/DONE handshake, zero-operand ERROR, BUSY while iterating.
module gcd_lcm_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    gcd_lcm_engine_if.slave   bus
);

    state_t             r_state;
    logic [2*WIDTH-1:0] r_x;
    logic [2*WIDTH-1:0] r_z;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic               r_mode;
    logic               r_errPend;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [2*WIDTH-1:0] r_y;

    logic [2*WIDTH-1:0] w_xNext;
    logic [2*WIDTH-1:0] w_zNext;
    logic               w_equal;

    gcd_lcm_dp #(
        .WIDTH   (WIDTH)
    ) u_dp (
        .i_x     (r_x),
        .i_z     (r_z),
        .i_opA   (r_opA),
        .i_opB   (r_opB),
        .i_mode  (r_mode),
        .o_xNext (w_xNext),
        .o_zNext (w_zNext),
        .o_equal (w_equal)
    );

    // A zero operand parks in FIN for one silent cycle so its DONE lands one edge
    // after capture, the same timing as an A==B request, without raising BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_z       <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_mode    <= MODE_GCD;
            r_errPend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_y       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_opA   <= bus.i_a;
                        r_opB   <= bus.i_b;
                        r_x     <= {{WIDTH{1'b0}}, bus.i_a};
                        r_z     <= {{WIDTH{1'b0}}, bus.i_b};
                        r_mode  <= bus.i_mode;
                        r_error <= 1'b0;
                        if ((bus.i_a == '0) || (bus.i_b == '0)) begin
                            r_errPend <= 1'b1;
                            r_state   <= FIN;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_equal) begin
                        r_y     <= r_x;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_x <= w_xNext;
                        r_z <= w_zNext;
                    end
                end
                FIN: begin
                    if (r_errPend) begin
                        r_errPend <= 1'b0;
                        r_done    <= 1'b1;
                        r_error   <= 1'b1;
                        r_y       <= '0;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_error = r_error;
    assign bus.o_y     = r_y;

endmodule
